serial_adder: RTL and testbench



---
 rtl/serial_adder_pkg.sv | 18 +
 rtl/digit_adder.sv | 23 ++
 rtl/serial_adder.sv | 113 +++++++++++
 tb/tb_serial_adder.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/serial_adder_pkg.sv
// Shared state encoding and sizing helpers for the digit-serial adder.
package adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Counter width for n states; never narrower than one bit.
  function automatic int cnt_w(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) w++;
    return w;
  endfunction

endpackage

// File: rtl/digit_adder.sv
// Combinational DIGIT-bit ripple-carry adder with carry in/out.
module digit_adder #(
  parameter int DIGIT = 1
) (
  input  logic [DIGIT-1:0] a,
  input  logic [DIGIT-1:0] b,
  input  logic             cin,
  output logic [DIGIT-1:0] s,
  output logic             cout
);

  logic [DIGIT:0] c;

  assign c[0] = cin;

  for (genvar i = 0; i < DIGIT; i++) begin : g_fa
    assign s[i]   = a[i] ^ b[i] ^ c[i];
    assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end

  assign cout = c[DIGIT];

endmodule

// File: rtl/serial_adder.sv
// Digit-serial adder: {carry,sum} = a + b + cin, DIGIT bits per clock,
// with a start/ready/done handshake.
module serial_adder
  import adder_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry,
  output logic             done
);

  localparam int NDIG = WIDTH / DIGIT;
  localparam int CW   = cnt_w(NDIG);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, psum_q, psum_d, sum_q, sum_d;
  logic             c_q, c_d, carry_q, carry_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic [DIGIT-1:0]       dsum;
  logic                   dcout;
  logic [WIDTH+DIGIT-1:0] psum_cat;
  logic [WIDTH-1:0]       psum_nxt;
  logic                   accept;

  digit_adder #(.DIGIT(DIGIT)) u_digit (
    .a    (a_q[DIGIT-1:0]),
    .b    (b_q[DIGIT-1:0]),
    .cin  (c_q),
    .s    (dsum),
    .cout (dcout)
  );

  // New digit enters at the top; works even when DIGIT == WIDTH.
  assign psum_cat = {dsum, psum_q} >> DIGIT;
  assign psum_nxt = psum_cat[WIDTH-1:0];

  assign ready  = (state_q != RUN);
  assign done   = (state_q == DONE);
  assign accept = start && ready;
  assign sum    = sum_q;
  assign carry  = carry_q;

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    c_d     = c_q;
    psum_d  = psum_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    case (state_q)
      IDLE, DONE: begin
        if (accept) begin
          a_d     = a;
          b_d     = b;
          c_d     = cin;
          psum_d  = '0;
          cnt_d   = '0;
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        psum_d = psum_nxt;
        c_d    = dcout;
        a_d    = a_q >> DIGIT;
        b_d    = b_q >> DIGIT;
        cnt_d  = cnt_q + CW'(1);
        if (cnt_q == CW'(NDIG - 1)) begin
          sum_d   = psum_nxt;
          carry_d = dcout;
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= 1'b0;
      psum_q  <= '0;
      cnt_q   <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      c_q     <= c_d;
      psum_q  <= psum_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// Bench for serial_adder: directed table, handshake corner cases, and a
// random regression over DIGIT = 1,2,4,8 against plain a+b+cin.
module tb_serial_adder;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] a = '0, b = '0;
  logic       cin = 1'b0;

  logic       start_v [4];
  logic       ready_v [4];
  logic       done_v  [4];
  logic       carry_v [4];
  logic [7:0] sum_v   [4];

  logic h_start = 1'b0, h_a = 1'b0, h_b = 1'b0, h_cin = 1'b0;
  logic h_ready, h_sum, h_carry, h_done;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    serial_adder #(.WIDTH(8), .DIGIT(1 << g)) dut (
      .clk   (clk),
      .rst   (rst),
      .start (start_v[g]),
      .a     (a),
      .b     (b),
      .cin   (cin),
      .ready (ready_v[g]),
      .sum   (sum_v[g]),
      .carry (carry_v[g]),
      .done  (done_v[g])
    );
  end

  serial_adder #(.WIDTH(1), .DIGIT(1)) u_half (
    .clk   (clk),
    .rst   (rst),
    .start (h_start),
    .a     (h_a),
    .b     (h_b),
    .cin   (h_cin),
    .ready (h_ready),
    .sum   (h_sum),
    .carry (h_carry),
    .done  (h_done)
  );

  typedef struct {
    int         k;
    logic [7:0] a, b;
    logic       cin;
    logic [7:0] esum;
    logic       ecarry;
    int         elat;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Launch one add on instance k and wait (bounded) for its done pulse.
  task automatic run_add(input int k, input logic [7:0] ta, input logic [7:0] tb_,
                         input logic tc, output logic [7:0] rs, output logic rc,
                         output int lat);
    @(negedge clk);
    a = ta; b = tb_; cin = tc; start_v[k] = 1'b1;
    @(negedge clk);
    start_v[k] = 1'b0;
    chk("busy_ready", ready_v[k], 0);
    lat = 0;
    while (!done_v[k] && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    chk("done_seen", done_v[k], 1);
    rs = sum_v[k];
    rc = carry_v[k];
    @(negedge clk);
    chk("done_width", done_v[k], 0);
  endtask

  vec_t       vecs [7];
  logic [7:0] rs;
  logic       rc;
  int         lat, ndone;
  logic [8:0] model;

  initial begin
    for (int i = 0; i < 4; i++) start_v[i] = 1'b0;
    vecs[0] = '{0, 8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, 8};
    vecs[1] = '{0, 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 8};
    vecs[2] = '{0, 8'hFF, 8'h00, 1'b1, 8'h00, 1'b1, 8};
    vecs[3] = '{0, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 8};
    vecs[4] = '{2, 8'hA7, 8'h6C, 1'b1, 8'h14, 1'b1, 2};
    vecs[5] = '{3, 8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1};
    vecs[6] = '{1, 8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 4};

    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_ready", ready_v[0], 1);
    chk("rst_done",  done_v[0], 0);
    chk("rst_sum",   sum_v[0], 0);
    chk("rst_carry", carry_v[0], 0);

    foreach (vecs[i]) begin
      run_add(vecs[i].k, vecs[i].a, vecs[i].b, vecs[i].cin, rs, rc, lat);
      chk("vec_sum",   rs, vecs[i].esum);
      chk("vec_carry", rc, vecs[i].ecarry);
      chk("vec_lat",   lat, vecs[i].elat);
    end

    // WIDTH=DIGIT=1 with cin=0 behaves as a half adder.
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      h_a = i[0]; h_b = i[1]; h_start = 1'b1;
      @(negedge clk);
      h_start = 1'b0;
      @(negedge clk);
      chk("half_done",  h_done, 1);
      chk("half_sum",   h_sum, i[0] ^ i[1]);
      chk("half_carry", h_carry, i[0] & i[1]);
    end

    // Start while busy is ignored; exactly one done.
    @(negedge clk);
    a = 8'h12; b = 8'h34; cin = 1'b0; start_v[0] = 1'b1;
    @(negedge clk);
    start_v[0] = 1'b0;
    ndone = 0;
    for (int c = 0; c < 14; c++) begin
      if (c == 2) begin a = 8'hFF; b = 8'hFF; start_v[0] = 1'b1; end
      if (c == 3) start_v[0] = 1'b0;
      @(negedge clk);
      if (done_v[0]) ndone++;
    end
    chk("busy_ndone", ndone, 1);
    chk("busy_sum",   sum_v[0], 8'h46);
    chk("busy_carry", carry_v[0], 0);

    // Back-to-back: new start held during the DONE cycle.
    @(negedge clk);
    a = 8'h01; b = 8'h02; cin = 1'b0; start_v[0] = 1'b1;
    @(negedge clk);
    start_v[0] = 1'b0;
    lat = 0;
    while (!done_v[0] && lat < 40) begin @(negedge clk); lat++; end
    chk("b2b_first_done", done_v[0], 1);
    chk("b2b_first_sum",  sum_v[0], 8'h03);
    a = 8'h80; b = 8'h80; start_v[0] = 1'b1;
    @(negedge clk);
    start_v[0] = 1'b0;
    chk("b2b_done_drop", done_v[0], 0);
    chk("b2b_accepted",  ready_v[0], 0);
    chk("b2b_hold_sum",  sum_v[0], 8'h03);
    lat = 0;
    while (!done_v[0] && lat < 40) begin @(negedge clk); lat++; end
    chk("b2b_lat",   lat, 8);
    chk("b2b_sum",   sum_v[0], 8'h00);
    chk("b2b_carry", carry_v[0], 1);

    // Reset mid-RUN abandons the add; start on the reset edge is ignored.
    @(negedge clk);
    a = 8'h55; b = 8'h22; start_v[0] = 1'b1;
    @(negedge clk);
    start_v[0] = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1; start_v[0] = 1'b1;
    @(negedge clk);
    rst = 1'b0; start_v[0] = 1'b0;
    chk("mid_rst_ready", ready_v[0], 1);
    chk("mid_rst_done",  done_v[0], 0);
    chk("mid_rst_sum",   sum_v[0], 0);
    chk("mid_rst_carry", carry_v[0], 0);
    ndone = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (done_v[0]) ndone++;
    end
    chk("mid_rst_nodone", ndone, 0);
    run_add(0, 8'h55, 8'h22, 1'b1, rs, rc, lat);
    chk("post_rst_sum", {rc, rs}, 9'h078);

    // Random regression against plain arithmetic.
    for (int i = 0; i < 150; i++) begin
      int         k;
      logic [7:0] ra, rb;
      logic       rci;
      k   = $urandom_range(0, 3);
      ra  = 8'($urandom);
      rb  = 8'($urandom);
      rci = 1'($urandom);
      model = 9'(ra) + 9'(rb) + 9'(rci);
      run_add(k, ra, rb, rci, rs, rc, lat);
      chk("rand_result", {rc, rs}, model);
      chk("rand_lat", lat, 8 / (1 << k));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
